serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_fa.sv | 13 +
 rtl/serial_addsub.sv | 116 +++++++++++
 tb/tb_serial_addsub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the legal operand width range.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_fa.sv
// One-bit full-adder cell used by the serial datapath.
module serial_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial A+B / A-B: A is loaded in parallel, B arrives LSB first and the
// sum is shifted into the top of the accumulator one bit per enabled edge.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic             sub,
  input  logic             control,
  input  logic             in_B,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic b_eff, fa_s, fa_co, last_bit;

  // Subtraction is A + ~B + 1: invert B here, the +1 comes from carry=mode at load.
  assign b_eff    = in_B ^ mode_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  serial_fa u_fa (
    .a_i  (acc_q[0]),
    .b_i  (b_eff),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (start) begin
      // start wins in every state; the in_B on this edge is ignored
      state_d = RUN;
      acc_d   = a_in;
      carry_d = sub;
      mode_d  = sub;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (control) begin
            acc_d   = {fa_s, acc_q[WIDTH-1:1]};
            carry_d = fa_co;
            if (last_bit) begin
              // cnt stays at WIDTH-1 so it never wraps
              state_d = DONE;
              cout_d  = fa_co;
              ovf_d   = carry_q ^ fa_co;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign result    = acc_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: stimulus pushes hand-computed results, monitors pop on done.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] res;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0;
  logic [7:0] a8 = '0;
  logic       sub = 1'b0, control = 1'b0, in_B = 1'b0;

  logic [3:0] res4;
  logic [7:0] res8;
  logic       co4, ov4, busy4, done4;
  logic       co8, ov8, busy8, done8;

  exp_t q4[$];
  exp_t q8[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic done4_prev = 1'b0, done8_prev = 1'b0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_in(a4), .sub(sub),
    .control(control), .in_B(in_B), .result(res4), .carry_out(co4),
    .overflow(ov4), .busy(busy4), .done(done4)
  );

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a_in(a8), .sub(sub),
    .control(control), .in_B(in_B), .result(res8), .carry_out(co8),
    .overflow(ov8), .busy(busy8), .done(done8)
  );

  // monitors
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      n_chk++;
      if (done4_prev) begin
        n_err++;
        $display("FAIL w4_done_width: done high two cycles in a row");
      end
      n_chk++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL w4_unexpected_done: got res=%h co=%b ov=%b", res4, co4, ov4);
      end else begin
        e = q4.pop_front();
        if (res4 !== e.res[3:0] || co4 !== e.co || ov4 !== e.ov) begin
          n_err++;
          $display("FAIL w4_result: got res=%h co=%b ov=%b exp res=%h co=%b ov=%b",
                   res4, co4, ov4, e.res[3:0], e.co, e.ov);
        end
      end
    end
    if (done8) begin
      n_chk++;
      if (done8_prev) begin
        n_err++;
        $display("FAIL w8_done_width: done high two cycles in a row");
      end
      n_chk++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL w8_unexpected_done: got res=%h co=%b ov=%b", res8, co8, ov8);
      end else begin
        e = q8.pop_front();
        if (res8 !== e.res || co8 !== e.co || ov8 !== e.ov) begin
          n_err++;
          $display("FAIL w8_result: got res=%h co=%b ov=%b exp res=%h co=%b ov=%b",
                   res8, co8, ov8, e.res, e.co, e.ov);
        end
      end
    end
    done4_prev = done4;
    done8_prev = done8;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b exp %b", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_chk++;
    if (res4 !== 4'h0 || co4 !== 1'b0 || ov4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got res=%h co=%b ov=%b busy=%b done=%b exp all zero",
               name, res4, co4, ov4, busy4, done4);
    end
  endtask

  task automatic go4(input logic [3:0] a, input logic s);
    a4 = a; sub = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic go8(input logic [7:0] a, input logic s);
    a8 = a; sub = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    control = 1'b1; in_B = b;
    @(posedge clk); #1;
    control = 1'b0; in_B = 1'b0;
  endtask

  task automatic send_bits4(input logic [3:0] b);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
  endtask

  task automatic wait_done(input bit wide, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (wide ? done8 : done4) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout: done never seen exp done=1", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check_all_zero("reset_state");
    check1("reset_busy8", busy8, 1'b0);
    @(negedge clk); reset = 1'b1;

    // 5 + 7 = 12
    q4.push_back('{8'h0C, 1'b0, 1'b1});
    go4(4'b0101, 1'b0);
    send_bits4(4'b0111);
    wait_done(1'b0, "add_5_7");

    // 7 - 5 = 2, no borrow
    q4.push_back('{8'h02, 1'b1, 1'b0});
    go4(4'b0111, 1'b1);
    send_bits4(4'b0101);
    wait_done(1'b0, "sub_7_5");

    // 7 - 8: borrow and signed overflow
    q4.push_back('{8'h0F, 1'b0, 1'b1});
    go4(4'b0111, 1'b1);
    send_bits4(4'b1000);
    wait_done(1'b0, "sub_7_8");

    // stall for three cycles mid-operation
    q4.push_back('{8'h0C, 1'b0, 1'b1});
    go4(4'b0101, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      in_B = 1'b1;
      @(posedge clk); #1;
      check1("stall_busy", busy4, 1'b1);
    end
    in_B = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    wait_done(1'b0, "stall");

    // 8-bit: FF + 01 wraps to 00
    q8.push_back('{8'h00, 1'b1, 1'b0});
    go8(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(i == 0);
    wait_done(1'b1, "w8_ff_01");
    check1("w8_done_dropped", done8, 1'b0);

    // reset mid-operation
    go4(4'b0101, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1;
    check_all_zero("reset_held");
    reset = 1'b1;
    q4.push_back('{8'h0C, 1'b0, 1'b1});
    go4(4'b0101, 1'b0);
    check1("first_start_busy", busy4, 1'b1);
    send_bits4(4'b0111);
    wait_done(1'b0, "after_reset");

    // abort after two bits; restart edge also carries control=1/in_B=1
    go4(4'b0101, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    q4.push_back('{8'h04, 1'b0, 1'b0});
    control = 1'b1; in_B = 1'b1;
    go4(4'b0011, 1'b0);
    control = 1'b0; in_B = 1'b0;
    send_bits4(4'b0001);
    wait_done(1'b0, "restart");

    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (q4.size() != 0 || q8.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d results missing exp 0/0", q4.size(), q8.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
